// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// One input bit per clock; start/busy/done handshake with registered result and leading-zero mask.
module bin2bcd_seq #(
  parameter int NUM_BITS = 8,
  parameter int NUM_BCDS = (NUM_BITS * 301 + 999) / 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_BITS-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_BCDS*4-1:0] bcd_out,
  output logic [NUM_BCDS-1:0]   blank_mask
);

  localparam int BCD_W = NUM_BCDS * 4;
  localparam int SR_W  = BCD_W + NUM_BITS;
  localparam int CW    = $clog2(NUM_BITS + 1);
  localparam logic [NUM_BCDS-1:0] MASK_RST = ~NUM_BCDS'(1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_nxt;
  logic [SR_W-1:0]     sr, sr_nxt, sr_step;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [BCD_W-1:0]    adj;
  logic [NUM_BCDS-1:0] mask_nxt;
  logic                done_nxt;
  logic                load_result;

  // Add-3 correction on the pre-shift digits, all in parallel, then shift the whole register.
  always_comb begin
    adj = '0;
    for (int d = 0; d < NUM_BCDS; d++) begin
      if (sr[NUM_BITS + 4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = sr[NUM_BITS + 4*d +: 4] + 4'd3;
      else
        adj[4*d +: 4] = sr[NUM_BITS + 4*d +: 4];
    end
    sr_step = {adj, sr[NUM_BITS-1:0]} << 1;
  end

  // Leading-zero mask for the value being written out: scan from the top digit down.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    mask_nxt   = '0;
    for (int d = NUM_BCDS - 1; d >= 1; d--) begin
      zero_above  = zero_above & (sr_step[NUM_BITS + 4*d +: 4] == 4'd0);
      mask_nxt[d] = zero_above;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt    = {{BCD_W{1'b0}}, bin_in};
          cnt_nxt   = CW'(NUM_BITS - 1);
          state_nxt = CONV;
        end
      end
      CONV: begin
        sr_nxt  = sr_step;
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          cnt_nxt     = '0;
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          load_result = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= MASK_RST;
    end else begin
      sr   <= sr_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
      if (load_result) begin
        bcd_out    <= sr_step[SR_W-1 -: BCD_W];
        blank_mask <= mask_nxt;
      end
    end
  end

  assign busy = (state == CONV);

endmodule
